cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Synthesizable instruction-trace recorder that sits beside `cpu` and captures the per-cycle retirement stream (PC, instruction word, instruction class, conditional-execute result) into a circular buffer. It is a parametrised hardware successor to the simulation-only trace display. It adds programmable triggering, a configurable pre/post-trigger window and a ready/valid readout port, so traces can be pulled from silicon over a debug link.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC width.
- `INST_WIDTH`, 32: instruction word width.
- `DEPTH`, 64: buffer entries. Must be a power of 2 and ≥ 2.
- `PRE_TRIGGER`, 16: guaranteed pre-trigger entries. Must satisfy 0 ≤ PRE_TRIGGER < DEPTH.
- Derived value `POST = DEPTH - PRE_TRIGGER - 1`.
- Entry width `EW = ADDR_WIDTH + INST_WIDTH + 3`.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `resetn`, in, 1: asynchronous, active-low reset.
- `arm`, in, 1: one-cycle pulse that starts a new capture.
- `force_trig`, in, 1: pulse that triggers unconditionally while ARMED.
- `trace_valid`, in, 1: trace fields below are valid this cycle.
- `trace_pc`, in, ADDR_WIDTH: PC of the traced instruction.
- `trace_inst`, in, INST_WIDTH: instruction word.
- `trace_class`, in, 2: instruction class. 0 = unknown, 1 = data, 2 = load, 3 = branch.
- `trace_cond_exec`, in, 1: condition-code pass.
- `trig_pc_en`, in, 1: enables the PC-match trigger.
- `trig_pc`, in, ADDR_WIDTH: PC match value.
- `trig_inst_mask`, in, INST_WIDTH: instruction-match mask. A mask of 0 disables instruction matching.
- `trig_inst_value`, in, INST_WIDTH: instruction-match value.
- `rd_ready`, in, 1: reader accepts the current entry.
- `rd_valid`, out, 1: `rd_data` is valid.
- `rd_data`, out, EW: entry packed as {pc, inst, class, cond_exec}.
- `rd_last`, out, 1: current entry is the final one.
- `armed`, out, 1: high while in ARMED or POST.
- `done`, out, 1: high while in DONE.
- `trig_pos`, out, log2(DEPTH)+1: readout index of the trigger entry.
- `fill`, out, log2(DEPTH)+1: number of stored entries.

## Operation
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - Internal write pointer, fill count and post counter are 0.
  - Buffer contents are don't-care.
- States are IDLE, ARMED, POST and DONE.
- IDLE: no writes occur.
  - `arm` → ARMED. Clears the write pointer, `fill` and `trig_pos`.
- ARMED: each cycle with `trace_valid` high writes the entry at the write pointer.
  - The pointer increments mod DEPTH (wrap-around overwrites the oldest entry).
  - `fill` saturates at DEPTH.
- Trigger condition: `trace_valid` AND (`trig_pc_en` AND `trace_pc`==`trig_pc`, OR mask≠0 AND (`trace_inst` & mask)==value).
  - `force_trig` also triggers, with or without `trace_valid`.
- On a trigger in ARMED:
  - The triggering entry, if valid, is written.
  - The post counter is loaded with POST.
  - State → POST, or → DONE if POST==0.
- POST: every valid entry is written and decrements the counter. The write that takes the counter to 0 moves the state to DONE.
  - Further trigger conditions are ignored.
- Entering DONE:
  - `trig_pos` = `fill` − 1 − (POST − remaining post count). It equals PRE_TRIGGER when the buffer wrapped.
  - Read start = write pointer if `fill`==DEPTH, else 0.
- DONE: entries stream out oldest-first, `fill` entries in total.
  - A transfer happens on `rd_valid` & `rd_ready`.
  - `rd_last` is high with the `fill`-th entry.
  - After the last transfer: state → IDLE, `rd_valid` drops, `done` drops.
  - `rd_data` and `rd_last` are held stable while `rd_valid` is high and `rd_ready` is low.
- Force trigger with `fill`==0 in DONE: no `rd_valid` occurs, and the state returns to IDLE the cycle after entering DONE.
- `arm` in any non-IDLE state aborts the current capture and restarts ARMED as if from IDLE. Any in-flight readout is dropped and `rd_valid` falls the next cycle.
- `arm` takes priority over a same-cycle trigger or trace write. Neither the trigger nor the trace write is taken that cycle.
- `resetn` low mid-capture or mid-readout returns the block to reset values immediately.

## Timing
- Trace capture has zero input latency: fields are sampled on the same posedge as `trace_valid`.
- `armed` rises the cycle after `arm`.
- `done` rises the cycle after the final post-trigger write.
- Buffer RAM read is synchronous:
  - First `rd_valid` comes one cycle after `done` rises (prefetch).
  - Throughput is 1 entry per cycle while `rd_ready` is held high.
  - Each new entry appears the cycle after a transfer.
- Capture throughput is 1 entry per cycle with no back-pressure on the trace side.

## Test plan
Parameters for all scenarios: DEPTH=8, PRE_TRIGGER=3, POST=4.
- **Wrapped capture.** `arm`, then 20 valid PCs 0x00,0x04,…; `trig_pc`=0x28 (entry 10). Expected:
  - Entry 14 is the final write; `done` follows one cycle later.
  - `fill`=8, `trig_pos`=3.
  - Readout PCs are 0x1C..0x38, with `rd_last` on 0x38.
- **Short pre-history.** Trigger on the 2nd valid entry, then 4 more. Expected:
  - `fill`=6, `trig_pos`=1.
  - Readout is 6 entries starting at PC 0x00.
- **Instruction-mask trigger.** mask=0x0E000000, value=0x0A000000 (branch). Expected:
  - The first branch word triggers.
  - A preceding data op with a matching PC does not trigger, because `trig_pc_en`=0.
- **Readout back-pressure.** Toggle `rd_ready` 1,0,0,1,… during readout. Expected:
  - Every entry is delivered exactly once, in order.
  - `rd_data` is stable through stall cycles.
  - `rd_last` is high only on entry 8.
- **Abort.** `arm` during POST, then during DONE mid-readout. Expected:
  - `rd_valid` is 0 the next cycle.
  - `fill` is 0, `armed`=1.
  - A fresh capture completes correctly afterwards.
- **Asynchronous reset.** Drop `resetn` mid-POST. Expected: all outputs are 0 immediately and the state is IDLE; `arm` after release works normally.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace recorder: captures the retirement stream into a circular buffer
// around a programmable trigger, then streams the window out oldest-first.
module cpu_trace_buffer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int PRE_TRIGGER = 16
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 arm,
  input  logic                                 force_trig,
  input  logic                                 trace_valid,
  input  logic [ADDR_WIDTH-1:0]                trace_pc,
  input  logic [INST_WIDTH-1:0]                trace_inst,
  input  logic [1:0]                           trace_class,
  input  logic                                 trace_cond_exec,
  input  logic                                 trig_pc_en,
  input  logic [ADDR_WIDTH-1:0]                trig_pc,
  input  logic [INST_WIDTH-1:0]                trig_inst_mask,
  input  logic [INST_WIDTH-1:0]                trig_inst_value,
  input  logic                                 rd_ready,
  output logic                                 rd_valid,
  output logic [ADDR_WIDTH+INST_WIDTH+2:0]     rd_data,
  output logic                                 rd_last,
  output logic                                 armed,
  output logic                                 done,
  output logic [$clog2(DEPTH):0]               trig_pos,
  output logic [$clog2(DEPTH):0]               fill
);

  localparam int AW   = $clog2(DEPTH);
  localparam int EW   = ADDR_WIDTH + INST_WIDTH + 3;
  localparam int POST = DEPTH - PRE_TRIGGER - 1;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POST_W  = (AW+1)'(POST);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW-1:0] POST_C  = AW'(POST);
  localparam logic [AW-1:0] ONE_C   = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW-1:0]   post_q, post_d;
  logic [AW:0]     trig_pos_q, trig_pos_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     rleft_q, rleft_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [EW-1:0]   rdata_q;
  logic [EW-1:0]   mem [DEPTH];

  logic            we, re, enter_done;
  logic            pc_hit, inst_hit, trig;

  assign pc_hit   = trig_pc_en && (trace_pc == trig_pc);
  assign inst_hit = (trig_inst_mask != '0) && ((trace_inst & trig_inst_mask) == trig_inst_value);
  assign trig     = force_trig || (trace_valid && (pc_hit || inst_hit));

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    post_d     = post_q;
    trig_pos_d = trig_pos_q;
    rptr_d     = rptr_q;
    rleft_d    = rleft_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    we         = 1'b0;
    re         = 1'b0;
    enter_done = 1'b0;
    if (arm) begin
      // arm wins over everything, including a same-cycle trigger or write
      state_d    = S_ARMED;
      wptr_d     = '0;
      fill_d     = '0;
      trig_pos_d = '0;
      rleft_d    = '0;
      rvalid_d   = 1'b0;
      rlast_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          we = trace_valid;
          if (trig) begin
            post_d = POST_C;
            if (POST == 0) enter_done = 1'b1;
            else           state_d    = S_POST;
          end
        end
        S_POST: begin
          if (trace_valid) begin
            we     = 1'b1;
            post_d = post_q - ONE_C;
            if (post_q == ONE_C) enter_done = 1'b1;
          end
        end
        S_DONE: begin
          // prefetch the next entry whenever the output slot is free or draining
          if (rleft_q != '0 && (!rvalid_q || rd_ready)) begin
            re       = 1'b1;
            rvalid_d = 1'b1;
            rlast_d  = (rleft_q == ONE_W);
            rptr_d   = rptr_q + ONE_C;
            rleft_d  = rleft_q - ONE_W;
          end else if (rvalid_q && rd_ready) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end
          if ((rvalid_q && rd_ready && rlast_q) || (rleft_q == '0 && !rvalid_q))
            state_d = S_IDLE;
        end
        default: ;
      endcase
      if (we) begin
        wptr_d = wptr_q + ONE_C;
        if (fill_q != DEPTH_W) fill_d = fill_q + ONE_W;
      end
      if (enter_done) begin
        state_d    = S_DONE;
        trig_pos_d = fill_d - ONE_W - POST_W;
        rptr_d     = (fill_d == DEPTH_W) ? wptr_d : '0;
        rleft_d    = fill_d;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      trig_pos_q <= '0;
      rptr_q     <= '0;
      rleft_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      trig_pos_q <= trig_pos_d;
      rptr_q     <= rptr_d;
      rleft_q    <= rleft_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      if (re) rdata_q <= mem[rptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= {trace_pc, trace_inst, trace_class, trace_cond_exec};
  end

  assign rd_valid = rvalid_q;
  assign rd_data  = rdata_q;
  assign rd_last  = rlast_q;
  assign armed    = (state_q == S_ARMED) || (state_q == S_POST);
  assign done     = (state_q == S_DONE);
  assign trig_pos = trig_pos_q;
  assign fill     = fill_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: a queue-based capture model predicts the
// readout window; a negedge monitor pops and compares every transfer.
module tb_cpu_trace_buffer;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 8;
  localparam int PRE   = 3;
  localparam int POST  = DEPTH - PRE - 1;
  localparam int EW    = AW + IW + 3;

  logic          clk = 1'b0, resetn = 1'b0, arm = 1'b0, force_trig = 1'b0, trace_valid = 1'b0;
  logic [AW-1:0] trace_pc = '0, trig_pc = '0;
  logic [IW-1:0] trace_inst = '0, trig_inst_mask = '0, trig_inst_value = '0;
  logic [1:0]    trace_class = '0;
  logic          trace_cond_exec = 1'b0, trig_pc_en = 1'b0, rd_ready = 1'b0;
  logic          rd_valid, rd_last, armed, done;
  logic [EW-1:0] rd_data;
  logic [3:0]    trig_pos, fill;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH), .PRE_TRIGGER(PRE)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .force_trig(force_trig), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_class(trace_class),
    .trace_cond_exec(trace_cond_exec), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
    .trig_inst_mask(trig_inst_mask), .trig_inst_value(trig_inst_value), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .armed(armed), .done(done),
    .trig_pos(trig_pos), .fill(fill));

  typedef struct packed { logic [EW-1:0] data; logic last; } exp_t;

  exp_t          exp_q[$];
  logic [EW-1:0] hist[$];
  int            phase = 0;        // 0 not capturing, 1 waiting for trigger, 2 post-trigger
  int            post_left = 0;
  bit            done_chk = 0;
  logic [3:0]    exp_fill, exp_tpos;
  bit            stalled = 0;
  logic [EW-1:0] held_data;
  logic          held_last;
  int            rd_mode = 0;      // 0 ready, 1 pattern 1,0,0, 2 random, 3 held low
  int            rd_cnt = 0;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void record(input logic [EW-1:0] e);
    hist.push_back(e);
    if (hist.size() > DEPTH) void'(hist.pop_front());
  endfunction

  function automatic void finish_capture();
    exp_t t;
    for (int i = 0; i < hist.size(); i++) begin
      t.data = hist[i];
      t.last = (i == hist.size() - 1);
      exp_q.push_back(t);
    end
    exp_fill = 4'(hist.size());
    exp_tpos = 4'(hist.size() - 1 - POST);
    done_chk = 1;
    phase    = 0;
  endfunction

  // Apply the capture rules to the inputs sampled at this edge.
  function automatic void model_cycle();
    logic [EW-1:0] e;
    bit t;
    e = {trace_pc, trace_inst, trace_class, trace_cond_exec};
    if (arm) begin
      hist.delete();
      exp_q.delete();
      done_chk = 0;
      stalled  = 0;
      phase    = 1;
      return;
    end
    t = force_trig || (trace_valid && ((trig_pc_en && trace_pc == trig_pc) ||
        (trig_inst_mask != 0 && (trace_inst & trig_inst_mask) == trig_inst_value)));
    if (phase == 1) begin
      if (trace_valid) record(e);
      if (t) begin
        post_left = POST;
        if (post_left == 0) finish_capture();
        else phase = 2;
      end
    end else if (phase == 2 && trace_valid) begin
      record(e);
      post_left--;
      if (post_left == 0) finish_capture();
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_cycle();
    #1;
    arm        = 1'b0;
    force_trig = 1'b0;
    case (rd_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = (rd_cnt % 3 == 0);
      2:       rd_ready = 1'($urandom_range(0, 1));
      default: rd_ready = 1'b0;
    endcase
    rd_cnt++;
  endtask

  task automatic feed(input logic [AW-1:0] pc, input logic [IW-1:0] inst, input logic [1:0] cls);
    trace_valid = 1'b1; trace_pc = pc; trace_inst = inst; trace_class = cls;
    trace_cond_exec = 1'($urandom_range(0, 1));
    step();
  endtask

  task automatic do_arm();
    trace_valid = 1'b0;
    arm = 1'b1;
    step();
    chk("armed_after_arm", armed, 1);
    chk("fill_after_arm", fill, 0);
    chk("trig_pos_after_arm", trig_pos, 0);
    chk("rd_valid_after_arm", rd_valid, 0);
  endtask

  task automatic drain(input int mode);
    int n = 0;
    rd_mode = mode;
    trace_valid = 1'b0;
    while ((exp_q.size() != 0 || rd_valid || done) && n < 300) begin
      step();
      n++;
    end
    chk("drain_within_bound", n < 300, 1);
    chk("done_low_after_readout", done, 0);
    chk("rd_valid_low_after_readout", rd_valid, 0);
    rd_mode = 0;
  endtask

  function automatic logic [IW-1:0] data_word();
    return {4'h0, 3'b001, 25'($urandom)};
  endfunction

  // Monitor: compares each transfer against the scoreboard and checks stall stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stalled = 0;
        continue;
      end
      if (done_chk) begin
        chk("done_rise", done, 1);
        chk("fill_at_done", fill, exp_fill);
        chk("trig_pos_at_done", trig_pos, exp_tpos);
        chk("armed_low_at_done", armed, 0);
        chk("no_valid_during_prefetch", rd_valid, 0);
        done_chk = 0;
      end
      if (stalled) begin
        chk("stall_valid_held", rd_valid, 1);
        chk("stall_data_held", rd_data, held_data);
        chk("stall_last_held", rd_last, held_last);
      end
      stalled = 0;
      if (rd_valid) begin
        if (rd_ready) begin
          if (exp_q.size() == 0) chk("unexpected_rd_valid", rd_valid, 0);
          else begin
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_last", rd_last, e.last);
          end
        end else begin
          stalled   = 1;
          held_data = rd_data;
          held_last = rd_last;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k, nv;
    logic [AW-1:0] pc;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_last", rd_last, 0);
    chk("reset_armed", armed, 0);
    chk("reset_done", done, 0);
    chk("reset_trig_pos", trig_pos, 0);
    chk("reset_fill", fill, 0);
    resetn = 1'b1;
    step();

    // Wrapped capture: trigger on PC 0x28, window 0x1C..0x38
    trig_pc_en = 1'b1; trig_pc = 32'h28;
    do_arm();
    for (int i = 0; i < 20; i++) feed(32'(i * 4), 32'($urandom), 2'($urandom_range(0, 3)));
    drain(0);

    // Short pre-history: trigger on the 2nd entry
    trig_pc = 32'h04;
    do_arm();
    for (int i = 0; i < 6; i++) feed(32'(i * 4), 32'($urandom), 2'($urandom_range(0, 3)));
    drain(0);

    // Instruction-mask trigger; PC 0x08 matches but PC trigger is disabled
    trig_pc_en = 1'b0; trig_pc = 32'h08;
    trig_inst_mask = 32'h0E00_0000; trig_inst_value = 32'h0A00_0000;
    do_arm();
    for (int i = 0; i < 4; i++) feed(32'(i * 4), data_word(), 2'd1);
    feed(32'h10, {4'hE, 3'b101, 25'($urandom)}, 2'd3);
    for (int i = 5; i < 12; i++) feed(32'(i * 4), data_word(), 2'd1);
    drain(0);
    trig_inst_mask = '0; trig_inst_value = '0;

    // Readout back-pressure with gaps on the trace side
    trig_pc_en = 1'b1; trig_pc = 32'h30;
    rd_mode = 1;
    do_arm();
    nv = 0; pc = '0;
    while (nv < 24) begin
      if ($urandom_range(0, 2) == 0) begin trace_valid = 1'b0; step(); end
      else begin feed(pc, 32'($urandom), 2'($urandom_range(0, 3))); pc += 4; nv++; end
    end
    drain(1);

    // Abort during POST, then during a partially drained readout
    trig_pc = 32'h08;
    do_arm();
    for (int i = 0; i < 4; i++) feed(32'(i * 4), 32'($urandom), 2'd1);
    do_arm();
    trig_pc = 32'h108;
    for (int i = 0; i < 8; i++) feed(32'h100 + 32'(i * 4), 32'($urandom), 2'd2);
    trace_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 5 && k < 50) begin step(); k++; end
    chk("partial_readout_within_bound", k < 50, 1);
    rd_mode = 3; rd_ready = 1'b0;
    step();
    do_arm();
    trig_pc = 32'h208;
    for (int i = 0; i < 8; i++) feed(32'h200 + 32'(i * 4), 32'($urandom), 2'd0);
    drain(2);

    // Asynchronous reset mid-POST
    trig_pc = 32'h04;
    do_arm();
    for (int i = 0; i < 3; i++) feed(32'(i * 4), 32'($urandom), 2'd1);
    trace_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("areset_rd_valid", rd_valid, 0);
    chk("areset_rd_data", rd_data, 0);
    chk("areset_rd_last", rd_last, 0);
    chk("areset_armed", armed, 0);
    chk("areset_done", done, 0);
    chk("areset_trig_pos", trig_pos, 0);
    chk("areset_fill", fill, 0);
    hist.delete(); exp_q.delete(); phase = 0; done_chk = 0; stalled = 0;
    @(posedge clk); #1 resetn = 1'b1;
    trig_pc = 32'h14;
    do_arm();
    for (int i = 0; i < 10; i++) feed(32'(i * 4), 32'($urandom), 2'd3);
    drain(0);

    // Randomized captures with force triggers, gaps and ready patterns
    for (int it = 0; it < 6; it++) begin
      trig_pc_en = 1'($urandom_range(0, 1));
      trig_pc    = 32'($urandom_range(0, 15) * 4);
      rd_mode    = $urandom_range(0, 2);
      do_arm();
      k = 0; pc = '0;
      while (phase != 0 && k < 200) begin
        force_trig  = (k >= 40) || ($urandom_range(0, 11) == 0);
        trace_valid = ($urandom_range(0, 3) != 0);
        trace_pc = pc; trace_inst = 32'($urandom); trace_class = 2'($urandom_range(0, 3));
        trace_cond_exec = 1'($urandom_range(0, 1));
        if (trace_valid) pc += 4;
        step();
        k++;
      end
      chk("random_capture_within_bound", k < 200, 1);
      drain(rd_mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
